// File: rtl/stream_demux2.sv
// rtl/stream_demux2.sv - one-input, two-output stream demultiplexer with a 2-entry FIFO per port
// Bundle: stream_demux2_fifo (per-port buffer) followed by the stream_demux2 top.

module stream_demux2_fifo #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  pop,
  output logic                  valid,
  output logic                  not_full,
  output logic [DATA_WIDTH-1:0] head
);

  logic [DATA_WIDTH-1:0] mem [2];
  logic [1:0]            count;
  logic                  rd_ptr;
  logic                  wr_ptr;
  logic                  do_push;
  logic                  do_pop;

  assign valid    = (count != 2'd0);
  assign not_full = (count != 2'd2);
  assign head     = mem[rd_ptr];

  // Fullness is judged on the current count, so a pop never frees a slot for a same-cycle push.
  assign do_push = push & not_full;
  assign do_pop  = pop & valid;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem[0] <= '0;
      mem[1] <= '0;
      count  <= 2'd0;
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (do_pop) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

`ifdef FORMAL
  always_comb begin
    assert (count <= 2'd2);
    assert (valid == (count != 2'd0));
    assert (!(push && !not_full));
  end
`endif

endmodule

module stream_demux2 #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_select,
  output logic                  out_a_valid,
  input  logic                  out_a_ready,
  output logic [DATA_WIDTH-1:0] out_a_data,
  output logic                  out_b_valid,
  input  logic                  out_b_ready,
  output logic [DATA_WIDTH-1:0] out_b_data
);

  if (DEPTH != 2) begin : g_bad_depth
    $error("stream_demux2 supports DEPTH=2 only");
  end

  logic a_not_full;
  logic b_not_full;
  logic push_a;
  logic push_b;

  // Ready depends only on the selected port, so a stalled port never blocks the other.
  assign in_ready = in_select ? b_not_full : a_not_full;
  assign push_a   = in_valid & in_ready & ~in_select;
  assign push_b   = in_valid & in_ready & in_select;

  stream_demux2_fifo #(.DATA_WIDTH(DATA_WIDTH)) u_fifo_a (
    .clk       (clk),
    .reset     (reset),
    .push      (push_a),
    .push_data (in_data),
    .pop       (out_a_ready),
    .valid     (out_a_valid),
    .not_full  (a_not_full),
    .head      (out_a_data)
  );

  stream_demux2_fifo #(.DATA_WIDTH(DATA_WIDTH)) u_fifo_b (
    .clk       (clk),
    .reset     (reset),
    .push      (push_b),
    .push_data (in_data),
    .pop       (out_b_ready),
    .valid     (out_b_valid),
    .not_full  (b_not_full),
    .head      (out_b_data)
  );

endmodule
